// File: rtl/parity_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// parity_arbiter_pkg
//   Shared definitions for the parity_arbiter slice:
//     - state_e   : FSM state encoding (IDLE/START/WAIT/DONE)
//     - DEF_*     : default parameter values (requesters, data width, latency)
//     - idx_width : width of an index able to address 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package parity_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_DW         = 5;
  localparam int DEF_ENGINE_LAT = 7;

  // A one-entry range still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_arbiter_if.sv
// -----------------------------------------------------------------------------
// parity_arbiter_if
//   Requester-side bus of the parity arbiter.
//     req        : per-requester level request, held until its ack
//     req_data   : flattened data, requester i owns bits [i*DW +: DW]
//     ack        : one-hot, one-cycle result-valid pulse
//     res_parity : captured engine result {data, p}, held between acks
//   Modports:
//     master : the requester clients (drive req/req_data)
//     slave  : the arbiter (drives ack/res_parity)
// -----------------------------------------------------------------------------
interface parity_arbiter_if
  import parity_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [DW:0]        res_parity;

  modport master (
    output req,
    output req_data,
    input  ack,
    input  res_parity
  );

  modport slave (
    input  req,
    input  req_data,
    output ack,
    output res_parity
  );

endinterface

// File: rtl/parity_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// parity_arbiter_rr_pick
//   Combinational round-robin selector. Searches req_i upward, with wrap,
//   starting one position above the last-grant pointer.
//     req_i   : request vector
//     ptr_i   : index of the most recent grant
//     gnt_o   : index of the selected requester (0 when nothing is requested)
//     valid_o : at least one request is set
// -----------------------------------------------------------------------------
module parity_arbiter_rr_pick
  import parity_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   gnt_o,
  output logic            valid_o
);

  logic [PW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // the pointer is the one left standing.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_o   = '0;
    idx     = '0;
    valid_o = |req_i;
    for (int off = NREQ; off >= 1; off--) begin
      idx = PW'((int'(ptr_i) + off) % NREQ);
      if (req_i[idx]) gnt_o = idx;
    end
  end

endmodule

// File: rtl/parity_arbiter.sv
// -----------------------------------------------------------------------------
// parity_arbiter
//   Round-robin sequencer sharing one multi-cycle parity engine between NREQ
//   requesters. A granted word is sent to the engine with a one-cycle start
//   pulse; after ENGINE_LAT cycles the engine result is captured and returned
//   with a one-cycle ack to the granted requester.
//
//   Ports:
//     clk        : system clock, rising edge
//     n_rst      : asynchronous active-low reset
//     bus        : requester bus (req, req_data, ack, res_parity), slave side
//     busy       : high whenever the FSM is not IDLE
//     eng_data   : registered data word to the engine
//     eng_start  : one-cycle start pulse to the engine
//     eng_parity : engine result {data, ^data}
//     err        : sticky engine-result mismatch flag
//
//   Build option:
//     PARITY_ARBITER_CHECK_EN : when defined, the captured engine result is
//                               compared against {eng_data, ^eng_data} and any
//                               mismatch sets err until reset. Otherwise err
//                               is tied low.
// -----------------------------------------------------------------------------
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int DW         = DEF_DW,
  parameter int ENGINE_LAT = DEF_ENGINE_LAT
) (
  input  logic                   clk,
  input  logic                   n_rst,
  parity_arbiter_if.slave        bus,
  output logic                   busy,
  output logic [DW-1:0]          eng_data,
  output logic                   eng_start,
  input  logic [DW:0]            eng_parity,
  output logic                   err
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = idx_width(ENGINE_LAT);

  state_e          state_q;
  logic [PW-1:0]   gnt_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   eng_data_q;
  logic            eng_start_q;
  logic [NREQ-1:0] ack_q;
  logic [DW:0]     res_q;

  logic [PW-1:0]   pick_gnt;
  logic            pick_valid;
  logic [DW-1:0]   pick_data;

  parity_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  assign pick_data = bus.req_data[pick_gnt*DW +: DW];

`ifdef PARITY_ARBITER_CHECK_EN
  logic       err_q;
  logic [DW:0] local_res;
  assign local_res = {eng_data_q, ^eng_data_q};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      // Pointer starts on the last requester so requester 0 wins first.
      ptr_q       <= PW'(NREQ - 1);
      cnt_q       <= '0;
      eng_data_q  <= '0;
      eng_start_q <= 1'b0;
      ack_q       <= '0;
      res_q       <= '0;
`ifdef PARITY_ARBITER_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      // Pulse outputs fall back to zero unless a state raises them.
      eng_start_q <= 1'b0;
      ack_q       <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q       <= pick_gnt;
            ptr_q       <= pick_gnt;
            eng_data_q  <= pick_data;
            eng_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          cnt_q   <= CW'(ENGINE_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_q   <= eng_parity;
            ack_q   <= NREQ'(1) << gnt_q;
            state_q <= DONE;
`ifdef PARITY_ARBITER_CHECK_EN
            if (eng_parity != local_res) err_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign eng_data       = eng_data_q;
  assign eng_start      = eng_start_q;
  assign bus.ack        = ack_q;
  assign bus.res_parity = res_q;

`ifdef PARITY_ARBITER_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parity_arbiter
//   Directed bench for parity_arbiter (NREQ=4, DW=5, ENGINE_LAT=7) with a
//   behavioural parity engine whose result is only correct once the engine
//   latency has elapsed after a start pulse.
// -----------------------------------------------------------------------------
module tb_parity_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 5;
  localparam int LAT  = 7;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          busy;
  logic [DW-1:0] eng_data;
  logic          eng_start;
  logic [DW:0]   eng_parity;
  logic          err;

  int checks = 0;
  int errors = 0;

  parity_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  parity_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .ENGINE_LAT (LAT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .busy       (busy),
    .eng_data   (eng_data),
    .eng_start  (eng_start),
    .eng_parity (eng_parity),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Engine model: latches data on start; result is right only once ecnt==1,
  // which happens LAT edges after the start is sampled. Before that it
  // returns the inverted result so an early capture is visible.
  logic [DW-1:0] e_d = '0;
  int            ecnt = 0;
  logic          corrupt = 1'b0;
  logic [DW:0]   e_good;

  always @(posedge clk) begin
    if (eng_start) begin
      e_d  <= eng_data;
      ecnt <= LAT;
    end else if (ecnt > 1) begin
      ecnt <= ecnt - 1;
    end
  end

  always_comb begin
    e_good = {e_d, ^e_d};
    if (corrupt && e_d == 5'h17) e_good[0] = ~e_good[0];
    eng_parity = (ecnt == 1) ? e_good : ~e_good;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called with requester idx already requesting; returns at the IDLE
  // cycle after its ack with req[idx] dropped (optionally re-raised).
  task automatic txn(input int idx, input logic [4:0] d, input logic [5:0] r,
                     input bit reraise);
    int n;
    bit bad;
    n = 0;
    @(negedge clk);
    while (!eng_start && n < 40) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("start_gap%0d", idx), n, 0);
    check($sformatf("eng_data%0d", idx), eng_data, d);
    check("busy_start", busy, 1);
    bad = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (bus.ack !== '0 || eng_start !== 1'b0 || busy !== 1'b1 || eng_data !== d) bad = 1;
    end
    check("wait_quiet", bad, 0);
    @(negedge clk);
    check($sformatf("ack%0d", idx), bus.ack, 32'(1) << idx);
    check($sformatf("res%0d", idx), bus.res_parity, r);
    bus.req[idx] = 1'b0;
    @(negedge clk);
    check("idle_after", {busy, eng_start, |bus.ack}, 0);
    check("res_held", bus.res_parity, r);
    if (reraise) bus.req[idx] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bit bad;
    n_rst        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_ack", bus.ack, 0);
    check("rst_start", eng_start, 0);
    check("rst_data", eng_data, 0);
    check("rst_res", bus.res_parity, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Single requests
    bus.req_data[0*DW +: DW] = 5'h01;
    bus.req[0] = 1'b1;
    txn(0, 5'h01, 6'h03, 0);
    bus.req_data[2*DW +: DW] = 5'h17;
    bus.req[2] = 1'b1;
    txn(2, 5'h17, 6'h2E, 0);
    bus.req_data[3*DW +: DW] = 5'h0E;
    bus.req[3] = 1'b1;
    txn(3, 5'h0E, 6'h1D, 0);

    // All four at once: pointer sits on 3, so order 0,1,2,3
    bus.req_data = {5'h00, 5'h10, 5'h1F, 5'h05};
    bus.req      = 4'hF;
    txn(0, 5'h05, 6'h0A, 0);
    txn(1, 5'h1F, 6'h3F, 0);
    txn(2, 5'h10, 6'h21, 0);
    txn(3, 5'h00, 6'h00, 0);

    // Fairness between two persistent requesters
    bus.req_data[0*DW +: DW] = 5'h03;
    bus.req_data[1*DW +: DW] = 5'h08;
    bus.req[0] = 1'b1;
    bus.req[1] = 1'b1;
    txn(0, 5'h03, 6'h06, 1);
    txn(1, 5'h08, 6'h11, 1);
    txn(0, 5'h03, 6'h06, 0);
    txn(1, 5'h08, 6'h11, 0);
    check("err_clean", err, 0);

    // Reset in the middle of WAIT
    bus.req_data[2*DW +: DW] = 5'h0A;
    bus.req[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!eng_start && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("mid_start_seen", eng_start, 1);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", eng_data, 0);
    check("mid_rst_res", bus.res_parity, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack !== '0 || busy !== 1'b0 || eng_start !== 1'b0) bad = 1;
    end
    check("mid_rst_hold", bad, 0);
    n_rst = 1'b1;
    txn(2, 5'h0A, 6'h14, 0);

    // Engine returns a wrong parity bit for 5'h17
    corrupt = 1'b1;
    bus.req_data[0*DW +: DW] = 5'h17;
    bus.req[0] = 1'b1;
    txn(0, 5'h17, 6'h2F, 0);
    corrupt = 1'b0;
`ifdef PARITY_ARBITER_CHECK_EN
    check("err_set", err, 1);
`else
    check("err_tied", err, 0);
`endif
    bus.req_data[1*DW +: DW] = 5'h01;
    bus.req[1] = 1'b1;
    txn(1, 5'h01, 6'h03, 0);
`ifdef PARITY_ARBITER_CHECK_EN
    check("err_sticky", err, 1);
`else
    check("err_still0", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
